// File: rtl/conv_enc_213_tx_pkg.sv
// rtl/conv_enc_213_tx_pkg.sv - shared constants, FSM states and encoder helper for conv_enc_213_tx
package conv_enc_213_tx_pkg;

    localparam int         SYM_W          = 2;
    localparam int         CNT_W          = 5;
    localparam int         DEF_FIFO_DEPTH = 4;
    localparam logic [2:0] DEF_G0         = 3'b111;
    localparam logic [2:0] DEF_G1         = 3'b101;
    localparam int         DEF_FILL_SYMS  = 15;
    localparam int         DEF_HOLD_FILL  = 3;
    localparam int         DEF_HOLD_TB    = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

    // Register vector is {u, s1, s2}; each code bit is the parity of the taps.
    function automatic logic [SYM_W-1:0] conv_encode(
        input logic       u,
        input logic       s1,
        input logic       s2,
        input logic [2:0] g0,
        input logic [2:0] g1
    );
        logic [2:0] r;
        r = {u, s1, s2};
        return {^(r & g0), ^(r & g1)};
    endfunction

endpackage

// File: rtl/conv_enc_213_tx_fifo.sv
// rtl/conv_enc_213_tx_fifo.sv - info-bit FIFO, one data bit plus frame-last flag per entry
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset (flushes pointers)
//   push, push_bit,       write request with data bit and last flag (ignored when full)
//   push_last
//   pop                   read request (ignored when empty)
//   pop_bit, pop_last     head-of-queue entry
//   full, empty           occupancy flags
module conv_enc_213_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic push_bit,
    input  logic push_last,
    input  logic pop,
    output logic pop_bit,
    output logic pop_last,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] bit_mem;
    logic [DEPTH-1:0] last_mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            bit_mem[wr_ptr[AW-1:0]]  <= push_bit;
            last_mem[wr_ptr[AW-1:0]] <= push_last;
        end
    end

    assign pop_bit  = bit_mem[rd_ptr[AW-1:0]];
    assign pop_last = last_mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_enc_213_tx.sv
// rtl/conv_enc_213_tx.sv - rate-1/2 K=3 convolutional encoder with symbol pacing for a Viterbi decoder
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   bit_in       information bit
//   bit_valid    bit_in / bit_last qualifier
//   bit_last     bit_in closes the current frame
//   bit_ready    buffer can accept a bit (low while in reset)
//   sym_out      coded symbol {c0, c1}
//   seq_ready    symbol stream active (LOAD and HOLD)
//   frame_done   one-clock pulse after the final tail symbol has been held
module conv_enc_213_tx
    import conv_enc_213_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [2:0] G0         = DEF_G0,
    parameter logic [2:0] G1         = DEF_G1,
    parameter int         FILL_SYMS  = DEF_FILL_SYMS,
    parameter int         HOLD_FILL  = DEF_HOLD_FILL,
    parameter int         HOLD_TB    = DEF_HOLD_TB
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             bit_last,
    output logic             bit_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             seq_ready,
    output logic             frame_done
);

    enc_state_t       state_q;
    enc_state_t       state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] sym_cnt_q;
    logic [CNT_W-1:0] hold_val;
    logic [1:0]       tail_rem_q;
    logic             tail_end_q;
    logic             s1_q;
    logic             s2_q;
    logic [SYM_W-1:0] sym_q;
    logic             ready_en_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_bit;
    logic             fifo_last;
    logic             fifo_full;
    logic             fifo_empty;
    logic             tail_pending;
    logic             pending;
    logic             u;

    assign fifo_push = bit_valid & bit_ready;

    conv_enc_213_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_bit (bit_in),
        .push_last(bit_last),
        .pop      (fifo_pop),
        .pop_bit  (fifo_bit),
        .pop_last (fifo_last),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Tail loads take priority over queued bits: bits of the next frame wait in the FIFO.
    assign tail_pending = (tail_rem_q != 2'd0);
    assign pending      = tail_pending | ~fifo_empty;
    assign u            = tail_pending ? 1'b0 : fifo_bit;
    assign hold_val     = (sym_cnt_q < CNT_W'(FILL_SYMS)) ? CNT_W'(HOLD_FILL) : CNT_W'(HOLD_TB);

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop = ~tail_pending;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                // hold_q parks at 1 when starved, keeping the current symbol on sym_out.
                if (hold_q <= CNT_W'(1)) begin
                    if (tail_end_q) begin
                        state_d = ST_DONE;
                    end else if (pending) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            sym_cnt_q  <= '0;
            tail_rem_q <= 2'd0;
            tail_end_q <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            sym_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    sym_cnt_q <= '0;
                end
                ST_LOAD: begin
                    sym_q <= conv_encode(u, s1_q, s2_q, G0, G1);
                    s1_q  <= u;
                    s2_q  <= s1_q;
                    // The LOAD clock is the first clock of the symbol period.
                    hold_q <= hold_val - 1'b1;
                    if (sym_cnt_q < CNT_W'(FILL_SYMS)) begin
                        sym_cnt_q <= sym_cnt_q + 1'b1;
                    end
                    if (tail_pending) begin
                        tail_rem_q <= tail_rem_q - 1'b1;
                        tail_end_q <= (tail_rem_q == 2'd1);
                    end else begin
                        tail_end_q <= 1'b0;
                        if (fifo_last) begin
                            tail_rem_q <= 2'd2;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q > CNT_W'(1)) begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    s1_q       <= 1'b0;
                    s2_q       <= 1'b0;
                    sym_cnt_q  <= '0;
                    tail_end_q <= 1'b0;
                end
                default: begin
                    sym_cnt_q <= '0;
                end
            endcase
        end
    end

    assign sym_out    = sym_q;
    assign seq_ready  = (state_q == ST_LOAD) || (state_q == ST_HOLD);
    assign frame_done = (state_q == ST_DONE);
    assign bit_ready  = ready_en_q & ~fifo_full;

endmodule
